// File: rtl/inst_mem_loadable.sv
// Byte-addressed instruction memory with a registered 32-bit fetch port and a serial image loader.
// Optional fetch fault detection (misaligned / out-of-range) is enabled by defining INST_MEM_FAULT_EN.
module inst_mem_loadable #(
    parameter int unsigned DEPTH_BYTES = 256,
    parameter int unsigned ADDR_W      = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] Inst_Address,
    output logic [31:0]       Instruction,
    output logic              inst_valid,
    output logic              inst_fault,
    output logic              busy,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [7:0]        load_byte,
    input  logic              load_last,
    output logic              load_done,
    output logic              load_err
);
    localparam int unsigned AW  = $clog2(DEPTH_BYTES);
    localparam int unsigned PW  = AW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {
        RUN  = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t        state;
    logic [7:0]    mem [DEPTH_BYTES];
    logic [PW-1:0] ptr;
    logic [AW-1:0] idx;
    logic [31:0]   rd_word_c;
    logic          fault_c;
    logic          ovf_c;
    logic          wr_en_c;

    // Little-endian word assembly; byte indices wrap within the array.
    assign idx       = Inst_Address[AW-1:0];
    assign rd_word_c = {mem[idx + AW'(3)], mem[idx + AW'(2)], mem[idx + AW'(1)], mem[idx]};

`ifdef INST_MEM_FAULT_EN
    assign fault_c = (Inst_Address[1:0] != 2'b00) || (Inst_Address >= ADDR_W'(DEPTH_BYTES));
`else
    logic unused_addr_bits;
    assign fault_c          = 1'b0;
    assign unused_addr_bits = ^Inst_Address[ADDR_W-1:AW];
`endif

    // Pointer one past the last byte means the image has overflowed.
    assign ovf_c   = (ptr == PW'(DEPTH_BYTES));
    assign wr_en_c = (state == LOAD) && load_valid && !load_start && !ovf_c;
    assign busy    = (state == LOAD);

    // Storage deliberately has no reset so images survive a reset.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[ptr[AW-1:0]] <= load_byte;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= RUN;
            ptr         <= '0;
            Instruction <= '0;
            inst_valid  <= 1'b0;
            inst_fault  <= 1'b0;
            load_done   <= 1'b0;
            load_err    <= 1'b0;
        end else begin
            inst_valid <= 1'b0;
            load_done  <= 1'b0;
            case (state)
                RUN: begin
                    if (load_start) begin
                        state    <= LOAD;
                        ptr      <= '0;
                        load_err <= 1'b0;
                    end else if (fetch_req) begin
                        inst_valid  <= 1'b1;
                        inst_fault  <= fault_c;
                        Instruction <= fault_c ? NOP : rd_word_c;
                    end
                end
                LOAD: begin
                    if (load_start) begin
                        ptr      <= '0;
                        load_err <= 1'b0;
                    end else if (load_valid) begin
                        if (ovf_c) begin
                            load_err <= 1'b1;
                        end else begin
                            ptr <= ptr + PW'(1);
                        end
                        if (load_last) begin
                            state     <= RUN;
                            load_done <= 1'b1;
                        end
                    end
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: doc/inst_mem_loadable.md
# inst_mem_loadable

Parametrised, byte-addressed instruction memory for the RISC-V core, with a registered fetch port and a serial program-loader port. Software images can be streamed in after reset instead of being hard-coded. It sits between the PC/fetch stage and decode. The fetch side returns one little-endian 32-bit word per accepted request with fixed one-cycle latency. Fetches are blocked while a program load is in progress.

## Interface
- `DEPTH_BYTES`, 256 — memory size in bytes; power of two, ≥ 8.
- `ADDR_W`, 64 — width of `Inst_Address`.
- `clk` input 1 — single clock, rising edge.
- `reset` input 1 — asynchronous, active-low reset.
- `fetch_req` input 1 — fetch request, sampled at the rising edge.
- `Inst_Address` input ADDR_W — byte address of the instruction.
- `Instruction` output 32 — fetched word.
- `inst_valid` output 1 — `Instruction` / `inst_fault` valid this cycle.
- `inst_fault` output 1 — fetch fault (see Configuration).
- `busy` output 1 — loader active; fetches are ignored.
- `load_start` input 1 — begin a load at byte 0.
- `load_valid` input 1 — `load_byte` present.
- `load_byte` input 8 — data byte.
- `load_last` input 1 — qualifies the final byte of the image.
- `load_done` output 1 — one-cycle pulse when the load completes.
- `load_err` output 1 — sticky: image overflowed DEPTH_BYTES.

## Operation
- **Storage:** DEPTH_BYTES × 8 bit array. It is not cleared by reset; contents survive reset.
- **Word assembly:** `{mem[a+3], mem[a+2], mem[a+1], mem[a]}`. Index arithmetic is modulo DEPTH_BYTES using the low log2(DEPTH_BYTES) address bits.
- **FSM states:**
  - RUN (reset state).
  - LOAD.
- **RUN state:**
  - `load_start` moves to LOAD and clears the write pointer and `load_err`.
  - `load_start` takes priority over `fetch_req` and over `load_valid` in the same cycle; that fetch and byte are dropped.
- **LOAD state:**
  - Each `load_valid` writes `load_byte` to `mem[ptr]`, then increments `ptr`.
  - While `ptr == DEPTH_BYTES` (pointer is log2+1 bits wide), writes are discarded and `load_err` is set.
  - `load_valid && load_last` writes the byte (unless overflowed), returns to RUN and pulses `load_done`.
  - `load_start` in LOAD restarts: `ptr` is cleared to 0, `load_err` is cleared, and any byte in that cycle is dropped.
- **busy:** `busy = (state == LOAD)`. A `fetch_req` while busy is ignored; no `inst_valid` follows.
- **Reset mid-load:** returns to RUN. Bytes already written are retained. The image is incomplete; no `load_done` is issued.

## Timing
- **Reset values:**
  - `Instruction` = 0.
  - `inst_valid`, `inst_fault`, `busy`, `load_done`, `load_err` = 0.
  - `ptr` = 0.
- **Fetch latency:** a fetch accepted at edge N has `Instruction`, `inst_valid` and `inst_fault` registered at edge N and valid for the cycle after it. Fully pipelined: one request per cycle.
- **No request:** `inst_valid` drops to 0 and `Instruction` holds its last value.
- **Read-after-write:** a fetch in the cycle after `load_done` sees the newly loaded bytes.
- **load_done:** registered high for exactly the cycle after the edge that accepted the final byte. `busy` falls in the same cycle.
- **No backpressure on the loader:** every `load_valid` in LOAD is consumed that edge.

## Configuration
- **`INST_MEM_FAULT_EN` defined:**
  - Fault condition: `Inst_Address[1:0] != 0` or `Inst_Address >= DEPTH_BYTES`.
  - On a fault, the response cycle has `inst_fault` = 1 and `Instruction` = 32'h00000013 (NOP).
  - The memory is not read for a faulting fetch.
- **Not defined:**
  - `inst_fault` is tied to 0.
  - Any address is accepted, reduced modulo DEPTH_BYTES, and the +1..+3 byte indices wrap around.

## Test plan
- **Load then fetch:** reset; `load_start`; stream bytes 13 05 80 00 93 05 00 04 with `load_last` on the 8th.
  - `load_done` pulses once.
  - Fetch at 0 → 32'h00800513 and fetch at 4 → 32'h04000593, each one cycle after request.
- **Back-to-back fetches:** addresses 0, 4, 0 on consecutive cycles → three consecutive `inst_valid` cycles with the matching words. Idle cycle → `inst_valid` = 0.
- **Overflow:** DEPTH_BYTES = 8; load 10 bytes with `load_last` on the 10th.
  - `load_err` = 1 from the 9th byte onward; `load_done` pulses.
  - `mem[0..7]` hold the first 8 bytes.
  - Next `load_start` clears `load_err`.
- **Busy blocking:** `fetch_req` during LOAD → no `inst_valid`. Simultaneous `load_start` + `fetch_req` + `load_valid` in RUN → LOAD entered, byte not written, no response.
- **Reset mid-load:** assert `reset` after 3 bytes.
  - Outputs go to reset values immediately (asynchronous) and state returns to RUN.
  - A fetch at 0 returns the 3 new bytes plus the old byte 3.
- **Faults:**
  - With `INST_MEM_FAULT_EN`: fetch at 2 → `inst_fault` = 1, `Instruction` = 32'h00000013; fetch at DEPTH_BYTES → fault.
  - Without it: fetch at DEPTH_BYTES − 2 wraps, giving `{mem[1], mem[0], mem[DEPTH_BYTES−1], mem[DEPTH_BYTES−2]}`.
